// File: rtl/int_ctrl_pkg.sv
// Interrupt controller types and the pending-bit priority helpers.
`include "ctrl_encode_def.v"

package int_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } int_state_t;

    localparam int PEND_W  = 3;
    localparam int P_ILL   = 2;
    localparam int P_ECALL = 1;
    localparam int P_TMR   = 0;

    typedef logic [PEND_W-1:0] pend_t;

    // Priority order: illegal > ecall > timer.
    function automatic logic [2:0] pend_cause(input pend_t p);
        if (p[P_ILL])        return `INT_ILLEGAL_INSTR;
        else if (p[P_ECALL]) return `INT_ECALL;
        else if (p[P_TMR])   return `INT_TIMER;
        else                 return `INT_NONE;
    endfunction

    function automatic pend_t pend_sel(input pend_t p);
        if (p[P_ILL])        return pend_t'(3'b100);
        else if (p[P_ECALL]) return pend_t'(3'b010);
        else if (p[P_TMR])   return pend_t'(3'b001);
        else                 return pend_t'(3'b000);
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Controller-to-pipeline bundle: exception reports in, take/cause/EXL out.
interface int_ctrl_if;
    logic       PCWrite;
    logic       illegal_ex;
    logic       ecall_ex;
    logic       int_ret_ex;
    logic       timer_en;
    logic       INT_Signal;
    logic [2:0] INT_PEND;
    logic       EXL_Set;
    logic [2:0] int_cause_q;

    modport master (
        output PCWrite, illegal_ex, ecall_ex, int_ret_ex, timer_en,
        input  INT_Signal, INT_PEND, EXL_Set, int_cause_q
    );

    modport slave (
        input  PCWrite, illegal_ex, ecall_ex, int_ret_ex, timer_en,
        output INT_Signal, INT_PEND, EXL_Set, int_cause_q
    );
endinterface

// File: rtl/ctrl_encode_def.v
// Shared control encodings: interrupt cause codes and next-PC select values.
`ifndef CTRL_ENCODE_DEF_V
`define CTRL_ENCODE_DEF_V

`define INT_NONE          3'd0
`define INT_TIMER         3'd1
`define INT_ILLEGAL_INSTR 3'd2
`define INT_ECALL         3'd3

`define NPC_PLUS4   3'b000
`define NPC_BRANCH  3'b001
`define NPC_JUMP    3'b010
`define NPC_INT_RET 3'b100

`endif

// File: rtl/int_ctrl_timer_cnt.sv
// Free-running 0..TIMER_PERIOD-1 counter; tick is high in the wrap cycle.
module int_timer_cnt #(
    parameter int unsigned          CNT_W        = 32,
    parameter logic [CNT_W-1:0]     TIMER_PERIOD = CNT_W'(100000)
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == TIMER_PERIOD - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception controller: sticky pending bits, priority select, RUN/HANDLER FSM.
// Timer source present only when INT_TIMER_EN is defined; take is combinational, EXL registered.
`include "ctrl_encode_def.v"

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned      CNT_W        = 32,
    parameter logic [CNT_W-1:0] TIMER_PERIOD = CNT_W'(100000)
) (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);

    int_state_t r_state;
    int_state_t w_state_nxt;
    pend_t      r_pend;
    pend_t      w_set;
    pend_t      w_clr;
    logic [2:0] r_cause;
    logic [2:0] w_code;
    logic       w_take;
    logic       w_tick;
    logic       w_tmr_set;

`ifdef INT_TIMER_EN
    int_timer_cnt #(
        .CNT_W        (CNT_W),
        .TIMER_PERIOD (TIMER_PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );
`else
    assign w_tick = 1'b0;
`endif

    // A tick arriving while tmr is already pending simply re-sets the same bit.
    assign w_tmr_set = w_tick & bus.timer_en;
    assign w_set     = {bus.illegal_ex & bus.PCWrite, bus.ecall_ex & bus.PCWrite, w_tmr_set};
    assign w_code    = pend_cause(r_pend);
    assign w_clr     = w_take ? pend_sel(r_pend) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_take = (|r_pend) & bus.PCWrite;
                if (w_take) begin
                    w_state_nxt = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (bus.int_ret_ex && bus.PCWrite) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Set is ORed after the clear so a same-cycle re-raise of the taken cause survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_cause <= `INT_NONE;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (w_take) begin
                r_cause <= w_code;
            end
        end
    end

    assign bus.INT_Signal  = w_take;
    assign bus.INT_PEND    = w_code;
    assign bus.EXL_Set     = (r_state == ST_HANDLER);
    assign bus.int_cause_q = r_cause;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl (TIMER_PERIOD=8); timer checks run when INT_TIMER_EN is defined.
module tb_int_ctrl;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    int_ctrl_if bus ();

    int_ctrl #(
        .CNT_W        (32),
        .TIMER_PERIOD (32'd8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pcw;
        logic       ill;
        logic       ec;
        logic       ret;
        logic       sig;
        logic [2:0] pend;
        logic       exl;
        logic [2:0] cause;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t v(input logic pcw, input logic ill, input logic ec, input logic ret,
                               input logic sig, input logic [2:0] pend, input logic exl,
                               input logic [2:0] cause);
        vec_t r;
        r.pcw = pcw; r.ill = ill; r.ec = ec; r.ret = ret;
        r.sig = sig; r.pend = pend; r.exl = exl; r.cause = cause;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pcw, input logic ill, input logic ec, input logic ret);
        bus.PCWrite    = pcw;
        bus.illegal_ex = ill;
        bus.ecall_ex   = ec;
        bus.int_ret_ex = ret;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int takes;
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bus.timer_en = 1'b0;

        //              pcw   ill   ec    ret   sig   pend  exl   cause
        tbl[0]  = v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        tbl[1]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
        tbl[2]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd2);
        tbl[3]  = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd2);
        tbl[4]  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'd2);
        tbl[5]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd2);
        tbl[6]  = v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd3);
        tbl[7]  = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 3'd3);
        tbl[8]  = v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
        tbl[9]  = v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2);
        tbl[10] = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd2);
        tbl[11] = v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd2);
        tbl[12] = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 3'd3);
        tbl[13] = v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd3);
        tbl[14] = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 3'd2);
        tbl[15] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd2);
        tbl[16] = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
        tbl[17] = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig",   bus.INT_Signal,  0);
        chk("rst_pend",  bus.INT_PEND,    0);
        chk("rst_exl",   bus.EXL_Set,     0);
        chk("rst_cause", bus.int_cause_q, 0);
        rst = 1'b0;

        // Exception priority, return, stall and set-vs-clear sequences.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].pcw, tbl[i].ill, tbl[i].ec, tbl[i].ret);
            #2;
            chk($sformatf("vec%0d_sig", i),   bus.INT_Signal,  tbl[i].sig);
            chk($sformatf("vec%0d_pend", i),  bus.INT_PEND,    tbl[i].pend);
            chk($sformatf("vec%0d_exl", i),   bus.EXL_Set,     tbl[i].exl);
            chk($sformatf("vec%0d_cause", i), bus.int_cause_q, tbl[i].cause);
            next_cyc();
        end

        // ecall with PCWrite=0 is dropped.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        chk("stall_ecall_sig0", bus.INT_Signal, 0);
        next_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("stall_sig_%0d", i),  bus.INT_Signal, 0);
            chk($sformatf("stall_pend_%0d", i), bus.INT_PEND,   0);
            next_cyc();
        end

        // ecall captured, then stalled before the take.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        next_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("hold_sig_%0d", i),  bus.INT_Signal, 0);
            chk($sformatf("hold_pend_%0d", i), bus.INT_PEND,   3);
            next_cyc();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("hold_take_sig",  bus.INT_Signal, 1);
        chk("hold_take_pend", bus.INT_PEND,   3);
        next_cyc();
        chk("hold_take_exl",   bus.EXL_Set,     1);
        chk("hold_take_cause", bus.int_cause_q, 3);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        next_cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-handler with a cause pending.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        next_cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        next_cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        next_cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("pre_rst_exl",  bus.EXL_Set,  1);
        chk("pre_rst_pend", bus.INT_PEND, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_exl",   bus.EXL_Set,     0);
        chk("midrst_sig",   bus.INT_Signal,  0);
        chk("midrst_pend",  bus.INT_PEND,    0);
        chk("midrst_cause", bus.int_cause_q, 0);
        next_cyc();
        bus.timer_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

`ifdef INT_TIMER_EN
        // First wrap on the 8th edge after release; take follows in that cycle.
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("tmr_wait_%0d", k), bus.INT_Signal, 0);
        end
        @(posedge clk);
        #2;
        chk("tmr_take_sig",  bus.INT_Signal, 1);
        chk("tmr_take_pend", bus.INT_PEND,   1);
        chk("tmr_take_exl",  bus.EXL_Set,    0);
        @(posedge clk);
        #2;
        chk("tmr_exl",   bus.EXL_Set,     1);
        chk("tmr_cause", bus.int_cause_q, 1);
        chk("tmr_sig0",  bus.INT_Signal,  0);

        // Three wraps inside the handler collapse to one pending tick.
        takes = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #2;
            if (bus.INT_Signal) takes++;
        end
        chk("hnd_takes", takes, 0);
        chk("hnd_pend",  bus.INT_PEND, 1);
        bus.timer_en = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        next_cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        takes = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.INT_Signal) takes++;
            next_cyc();
        end
        chk("ret_tmr_takes", takes, 1);
        chk("ret_tmr_cause", bus.int_cause_q, 1);
        chk("ret_tmr_pend",  bus.INT_PEND,    0);
`else
        // Without the timer source, timer_en has no effect.
        takes = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (bus.INT_Signal) takes++;
        end
        chk("notmr_takes", takes, 0);
        chk("notmr_pend",  bus.INT_PEND, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        next_cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("notmr_ecall_pend", bus.INT_PEND,   3);
        chk("notmr_ecall_sig",  bus.INT_Signal, 1);
        next_cyc();
        chk("notmr_ecall_cause", bus.int_cause_q, 3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
